// File: rtl/alu_if.sv
// Operand/result bundle for the registered 8-bit ALU.
// The master drives operands and the opcode; the slave (the ALU) returns
// the registered result together with its status flags.
interface alu_if;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] ALU_Sel;
  logic [7:0] ALU_Out;
  logic       Carry;
  logic       Zero;
  logic       DivZero;

  modport master (
    output A,
    output B,
    output ALU_Sel,
    input  ALU_Out,
    input  Carry,
    input  Zero,
    input  DivZero
  );

  modport slave (
    input  A,
    input  B,
    input  ALU_Sel,
    output ALU_Out,
    output Carry,
    output Zero,
    output DivZero
  );
endinterface

// File: rtl/alu.sv
// Registered 8-bit unsigned ALU: add, sub, and, or, not, div, xor, mod.
// All results are formed combinationally from the operands and captured in
// one register stage, so outputs show the inputs of the previous edge.
// Division by zero is defined: DIV yields 8'hFF, MOD yields A, and the
// DivZero flag is raised alongside the substitute value.
module alu (
  input  logic clk,
  input  logic rst,
  alu_if.slave bus
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_NOT = 3'b100,
    OP_DIV = 3'b101,
    OP_XOR = 3'b110,
    OP_MOD = 3'b111
  } op_e;

  // Restoring divider, fully unrolled so it settles within one cycle.
  // Returns {quotient, remainder}. A zero divisor is screened out by the
  // caller, so the (all-ones quotient, remainder = dividend) behaviour of
  // the raw algorithm on zero never reaches the outputs unfiltered.
  function automatic logic [15:0] udivmod(input logic [7:0] num,
                                          input logic [7:0] den);
    logic [8:0] rem_v;
    logic [7:0] quot_v;
    rem_v  = 9'd0;
    quot_v = 8'd0;
    for (int i = 7; i >= 0; i--) begin
      rem_v = {rem_v[7:0], num[i[2:0]]};
      if (rem_v >= {1'b0, den}) begin
        rem_v          = rem_v - {1'b0, den};
        quot_v[i[2:0]] = 1'b1;
      end else begin
        quot_v[i[2:0]] = 1'b0;
      end
    end
    return {quot_v, rem_v[7:0]};
  endfunction

  op_e        op_s;
  logic [8:0] sum_s;
  logic [8:0] diff_s;
  logic [15:0] divmod_s;
  logic       b_is_zero_s;

  logic [7:0] result_s;
  logic       carry_s;
  logic       div_zero_s;
  logic       zero_s;

  logic [7:0] alu_out_r;
  logic       carry_r;
  logic       zero_r;
  logic       div_zero_r;

  // Shared arithmetic: 9-bit add/sub expose carry and borrow in bit 8.
  always_comb begin
    op_s        = op_e'(bus.ALU_Sel);
    sum_s       = {1'b0, bus.A} + {1'b0, bus.B};
    diff_s      = {1'b0, bus.A} - {1'b0, bus.B};
    divmod_s    = udivmod(bus.A, bus.B);
    b_is_zero_s = (bus.B == 8'h00);
  end

  // Select the result and flags for the current opcode.
  always_comb begin
    result_s   = 8'h00;
    carry_s    = 1'b0;
    div_zero_s = 1'b0;
    case (op_s)
      OP_ADD: begin
        result_s = sum_s[7:0];
        carry_s  = sum_s[8];
      end
      OP_SUB: begin
        result_s = diff_s[7:0];
        carry_s  = diff_s[8];
      end
      OP_AND: begin
        result_s = bus.A & bus.B;
      end
      OP_OR: begin
        result_s = bus.A | bus.B;
      end
      OP_NOT: begin
        result_s = ~bus.A;
      end
      OP_DIV: begin
        if (b_is_zero_s) begin
          result_s   = 8'hFF;
          div_zero_s = 1'b1;
        end else begin
          result_s   = divmod_s[15:8];
          div_zero_s = 1'b0;
        end
      end
      OP_XOR: begin
        result_s = bus.A ^ bus.B;
      end
      OP_MOD: begin
        if (b_is_zero_s) begin
          result_s   = bus.A;
          div_zero_s = 1'b1;
        end else begin
          result_s   = divmod_s[7:0];
          div_zero_s = 1'b0;
        end
      end
      default: begin
        result_s   = 8'h00;
        carry_s    = 1'b0;
        div_zero_s = 1'b0;
      end
    endcase
  end

  // Zero follows the value about to be registered, substitutes included.
  always_comb begin
    zero_s = (result_s == 8'h00);
  end

  // Pipeline register; reset forces the idle/cleared state immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_out_r  <= 8'h00;
      carry_r    <= 1'b0;
      zero_r     <= 1'b1;
      div_zero_r <= 1'b0;
    end else begin
      alu_out_r  <= result_s;
      carry_r    <= carry_s;
      zero_r     <= zero_s;
      div_zero_r <= div_zero_s;
    end
  end

  assign bus.ALU_Out = alu_out_r;
  assign bus.Carry   = carry_r;
  assign bus.Zero    = zero_r;
  assign bus.DivZero = div_zero_r;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the registered ALU: directed cases from the
// operation table, reset behaviour, then random back-to-back traffic
// checked against an arithmetic reference model.
module tb_alu;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_if bus ();

  alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {out[7:0], carry, zero, divzero} from plain integer arithmetic.
  function automatic logic [10:0] ref_model(input int a, input int b, input int sel);
    int r;
    logic c;
    logic dz;
    c  = 1'b0;
    dz = 1'b0;
    case (sel)
      0: begin r = a + b; c = (r > 255); r = r % 256; end
      1: begin c = (a < b); r = (a - b + 256) % 256; end
      2: r = a & b;
      3: r = a | b;
      4: r = 255 - a;
      5: if (b == 0) begin r = 255; dz = 1'b1; end else r = a / b;
      6: r = a ^ b;
      default: if (b == 0) begin r = a; dz = 1'b1; end else r = a % b;
    endcase
    return {r[7:0], c, (r == 0), dz};
  endfunction

  function automatic logic [10:0] observed();
    return {bus.ALU_Out, bus.Carry, bus.Zero, bus.DivZero};
  endfunction

  task automatic check(input string tag, input logic [10:0] exp);
    logic [10:0] obs;
    obs = observed();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got out=%h c=%b z=%b dz=%b exp out=%h c=%b z=%b dz=%b",
             tag, obs[10:3], obs[2], obs[1], obs[0], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Apply inputs (called just after an edge), clock once, sample 1 after.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
    bus.A       = a;
    bus.B       = b;
    bus.ALU_Sel = sel;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [2:0]  rs;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.A = 8'd0;
    bus.B = 8'd0;
    bus.ALU_Sel = 3'd0;
    #1;
    check("reset_initial", {8'h00, 1'b0, 1'b1, 1'b0});
    @(posedge clk);
    #1;
    check("reset_held_edge", {8'h00, 1'b0, 1'b1, 1'b0});
    rst = 1'b0;

    // Operation walk with A=12, B=4.
    step(8'd12, 8'd4, 3'b000); check("add_12_4", {8'd16,   1'b0, 1'b0, 1'b0});
    step(8'd12, 8'd4, 3'b001); check("sub_12_4", {8'd8,    1'b0, 1'b0, 1'b0});
    step(8'd12, 8'd4, 3'b010); check("and_12_4", {8'd4,    1'b0, 1'b0, 1'b0});
    step(8'd12, 8'd4, 3'b011); check("or_12_4",  {8'd12,   1'b0, 1'b0, 1'b0});
    step(8'd12, 8'd4, 3'b100); check("not_12",   {8'hF3,   1'b0, 1'b0, 1'b0});
    step(8'd12, 8'd4, 3'b101); check("div_12_4", {8'd3,    1'b0, 1'b0, 1'b0});

    // Division by zero.
    step(8'd12, 8'd0, 3'b101); check("div_by_0", {8'hFF,   1'b0, 1'b0, 1'b1});
    step(8'd12, 8'd0, 3'b111); check("mod_by_0", {8'd12,   1'b0, 1'b0, 1'b1});
    step(8'd0,  8'd0, 3'b111); check("mod_0_by_0", {8'd0,  1'b0, 1'b1, 1'b1});

    // Wrap and flags.
    step(8'd200, 8'd100, 3'b000); check("add_wrap",  {8'd44,  1'b1, 1'b0, 1'b0});
    step(8'd4,   8'd12,  3'b001); check("sub_borrow",{8'd248, 1'b1, 1'b0, 1'b0});
    step(8'd5,   8'd5,   3'b001); check("sub_zero",  {8'd0,   1'b0, 1'b1, 1'b0});
    step(8'd255, 8'd1,   3'b000); check("add_to_0",  {8'd0,   1'b1, 1'b1, 1'b0});

    // XOR / MOD.
    step(8'd12,  8'd5,   3'b110); check("xor_12_5",  {8'd9,   1'b0, 1'b0, 1'b0});
    step(8'd12,  8'd5,   3'b111); check("mod_12_5",  {8'd2,   1'b0, 1'b0, 1'b0});
    step(8'd255, 8'd255, 3'b110); check("xor_same",  {8'd0,   1'b0, 1'b1, 1'b0});
    step(8'd255, 8'd1,   3'b101); check("div_by_1",  {8'd255, 1'b0, 1'b0, 1'b0});
    step(8'd7,   8'd200, 3'b101); check("div_small", {8'd0,   1'b0, 1'b1, 1'b0});

    // Mid-cycle asynchronous reset, then release.
    step(8'd200, 8'd100, 3'b000);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {8'h00, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    bus.A = 8'd12; bus.B = 8'd4; bus.ALU_Sel = 3'b011;
    #1;
    check("post_release_hold", {8'h00, 1'b0, 1'b1, 1'b0});
    @(posedge clk);
    #1;
    check("post_release_first", {8'd12, 1'b0, 1'b0, 1'b0});

    // Random back-to-back traffic; B is zero often enough to hit div/mod-by-0.
    for (int n = 0; n < 300; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      rs = 3'($urandom);
      step(ra, rb, rs);
      check($sformatf("rand_%0d_sel%0d_a%0d_b%0d", n, rs, ra, rb),
            ref_model(int'(ra), int'(rb), int'(rs)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 8-bit registered arithmetic/logic unit with a 3-bit opcode select.
- Computes add, subtract, AND, OR, NOT, divide, XOR and modulo on two unsigned 8-bit operands.
- Result and status flags are registered on the clock, so the block sits as a single pipeline stage in a datapath.
- Division by zero is defined and flagged rather than left undefined.

Parameters:
- None. Widths are fixed: 8-bit data, 3-bit select.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous reset, active-high
- A  input  8  operand A, unsigned
- B  input  8  operand B, unsigned
- ALU_Sel  input  3  operation select
- ALU_Out  output  8  registered result
- Carry  output  1  registered carry-out (add) or borrow (sub); 0 for all other ops
- Zero  output  1  registered; 1 when ALU_Out is 8'h00
- DivZero  output  1  registered; 1 when op is 101 or 111 and B == 0

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: while rst=1, ALU_Out=8'h00, Carry=0, Zero=1, DivZero=0, asserted immediately without waiting for a clock edge. Reset has priority over everything.
- Latency: the result is combinational from A, B and ALU_Sel, captured on the rising clk edge. Outputs reflect the inputs sampled at the previous edge (1-cycle latency).
- No handshake: the register loads every cycle when rst=0.
- Reset deassertion: the first capture happens at the first rising edge after rst falls.
- Operations (all unsigned, results truncated to 8 bits):
  - 000 ADD: A+B mod 256. Carry = bit 8 of the 9-bit sum.
  - 001 SUB: A−B mod 256 (two's-complement wrap). Carry = borrow, i.e. 1 when A<B.
  - 010 AND: A & B.
  - 011 OR: A | B.
  - 100 NOT: ~A. B is ignored.
  - 101 DIV: A/B, quotient truncated toward zero. If B==0: ALU_Out=8'hFF, DivZero=1.
  - 110 XOR: A ^ B.
  - 111 MOD: A%B. If B==0: ALU_Out=A, DivZero=1.
- Carry is 0 for ops 010–111. DivZero is 0 for all ops other than 101 and 111 with B==0.
- Zero is derived from the value being registered into ALU_Out, including the division-by-zero substitute values.
- Divider: single-cycle combinational (restoring or equivalent) so the 1-cycle latency holds. No multicycle path.
- No X propagation: every select value produces a defined result.

Test Plan:
- Reset: assert rst mid-operation without a clock edge -> ALU_Out=00, Carry=0, Zero=1, DivZero=0 immediately. Release rst -> outputs update at the next edge.
- A=12, B=4, step ALU_Sel 000..101 one per cycle -> outputs one cycle later are:
  - 16 (Carry 0)
  - 8 (Carry 0)
  - 4
  - 12
  - 8'hF3
  - 3
  All with Zero=0, DivZero=0.
- Divide by zero: A=12, B=0:
  - ALU_Sel=101 -> ALU_Out=FF, DivZero=1, Zero=0.
  - ALU_Sel=111 -> ALU_Out=12, DivZero=1.
- Wrap and flags:
  - A=200, B=100, ADD -> 44, Carry=1.
  - A=4, B=12, SUB -> 248, Carry=1.
  - A=5, B=5, SUB -> 0, Zero=1, Carry=0.
- XOR/MOD: A=12, B=5:
  - 110 -> 9.
  - 111 -> 2.
  - A=255, B=255, XOR -> 0, Zero=1.
- Back-to-back: change A, B and ALU_Sel every cycle with random values -> each output cycle matches the reference model of the previous cycle's inputs.
